// File: rtl/tcm_pkg.sv
// Shared TCM definitions: default geometry, request record and port index type.
// Consumed by the TCM arbiter and the TCM block-RAM wrapper.
package tcm_pkg;

   localparam int TCM_ADDR_WIDTH = 14;
   localparam int TCM_DATA_WIDTH = 32;
   localparam int TCM_NUM_PORTS  = 3;
   localparam int TCM_BURST_LEN  = 4;

   typedef logic [$clog2(TCM_NUM_PORTS)-1:0] port_idx_t;

   typedef struct packed {
      logic [TCM_ADDR_WIDTH-1:0]   addr;
      logic                        we;
      logic [TCM_DATA_WIDTH/8-1:0] be;
      logic [TCM_DATA_WIDTH-1:0]   wdata;
   } tcm_req_t;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first set request at or after ptr, wrapping around.
// Purely combinational so it can be shared with the peripheral bus arbiter.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   int p;

   // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      p   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         p = (int'(ptr) + i) % N;
         if (req[p]) begin
            gnt    = '0;
            gnt[p] = 1'b1;
            idx    = IW'(p);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Round-robin arbiter sharing the single-port TCM among NUM_PORTS requesters,
// with a per-port burst limit and 1-cycle read response routing.
module tcm_port_arbiter
   import tcm_pkg::*;
#(
   parameter int NUM_PORTS  = TCM_NUM_PORTS,
   parameter int ADDR_WIDTH = TCM_ADDR_WIDTH,
   parameter int DATA_WIDTH = TCM_DATA_WIDTH,
   parameter int BURST_LEN  = TCM_BURST_LEN
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS-1:0]                req_valid,
   output logic [NUM_PORTS-1:0]                req_ready,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_PORTS-1:0]                req_we,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_be,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
   output logic [NUM_PORTS-1:0]                rsp_valid,
   output logic [DATA_WIDTH-1:0]               rsp_rdata,
   output logic                                tcm_en,
   output logic [DATA_WIDTH/8-1:0]             tcm_we,
   output logic [ADDR_WIDTH-1:0]               tcm_addr,
   output logic [DATA_WIDTH-1:0]               tcm_wdata,
   input  logic [DATA_WIDTH-1:0]               tcm_rdata
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int IW = $clog2(NUM_PORTS);
   localparam int CW = 4;
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
   localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
   logic [BW-1:0]         be_arr    [NUM_PORTS];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign be_arr[gi]    = req_be[gi*BW +: BW];
         assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   logic [IW-1:0]        ptr_reg, ptr_next;
   logic [IW-1:0]        owner_reg, owner_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic                 rd_pend_reg, rd_pend_next;
   logic [IW-1:0]        rd_port_reg, rd_port_next;

   logic [NUM_PORTS-1:0] grant_oh;
   logic [IW-1:0]        grant_idx;
   logic                 grant_any;
   logic                 we_sel;
   logic [CW-1:0]        cnt_bump;
   logic                 others_waiting;

   // Requests are masked while reset is held so nothing is granted during reset.
   rr_pick #(
      .N  (NUM_PORTS),
      .IW (IW)
   ) u_pick (
      .req (req_valid & {NUM_PORTS{rst}}),
      .ptr (ptr_reg),
      .gnt (grant_oh),
      .idx (grant_idx),
      .any (grant_any)
   );

   assign we_sel    = req_we[grant_idx];
   assign req_ready = grant_oh;
   assign tcm_en    = grant_any;
   assign tcm_addr  = addr_arr[grant_idx];
   assign tcm_wdata = wdata_arr[grant_idx];
   assign tcm_we    = be_arr[grant_idx] & {BW{we_sel & grant_any}};
   assign rsp_rdata = tcm_rdata;

   always_comb begin
      rsp_valid = '0;
      if (rd_pend_reg) begin
         rsp_valid[rd_port_reg] = 1'b1;
      end
   end

   always_comb begin
      ptr_next       = ptr_reg;
      owner_next     = owner_reg;
      cnt_next       = cnt_reg;
      rd_pend_next   = grant_any & ~we_sel;
      rd_port_next   = grant_idx;
      others_waiting = |(req_valid & ~grant_oh);
      cnt_bump       = CW'(1);
      if (grant_idx == owner_reg) begin
         cnt_bump = (cnt_reg >= BURST_MAX) ? cnt_reg : cnt_reg + CW'(1);
      end
      if (grant_any) begin
         owner_next = grant_idx;
         // Rotate only when the burst is spent and someone else is waiting.
         if ((cnt_bump >= BURST_MAX) && others_waiting) begin
            ptr_next = (grant_idx == LAST_PORT) ? '0 : grant_idx + IW'(1);
            cnt_next = '0;
         end else begin
            ptr_next = grant_idx;
            cnt_next = cnt_bump;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_reg     <= '0;
         owner_reg   <= '0;
         cnt_reg     <= '0;
         rd_pend_reg <= 1'b0;
         rd_port_reg <= '0;
      end else begin
         ptr_reg     <= ptr_next;
         owner_reg   <= owner_next;
         cnt_reg     <= cnt_next;
         rd_pend_reg <= rd_pend_next;
         rd_port_reg <= rd_port_next;
      end
   end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: TCM behavioural model, shadow-memory scoreboard,
// grant-order vector table and hand-written reset / burst / stream sequences.
module tb_tcm_port_arbiter;

   localparam int NP = 3;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]     v_valid;
   logic [AW-1:0]     v_addr  [NP];
   logic              v_we    [NP];
   logic [BW-1:0]     v_be    [NP];
   logic [DW-1:0]     v_wdata [NP];

   logic [NP-1:0]     req_ready;
   logic [NP*AW-1:0]  req_addr;
   logic [NP-1:0]     req_we;
   logic [NP*BW-1:0]  req_be;
   logic [NP*DW-1:0]  req_wdata;
   logic [NP-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              tcm_en;
   logic [BW-1:0]     tcm_we;
   logic [AW-1:0]     tcm_addr;
   logic [DW-1:0]     tcm_wdata;
   logic [DW-1:0]     tcm_rdata;

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_pack
         assign req_addr[gi*AW +: AW]  = v_addr[gi];
         assign req_we[gi]             = v_we[gi];
         assign req_be[gi*BW +: BW]    = v_be[gi];
         assign req_wdata[gi*DW +: DW] = v_wdata[gi];
      end
   endgenerate

   tcm_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (v_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .tcm_en    (tcm_en),
      .tcm_we    (tcm_we),
      .tcm_addr  (tcm_addr),
      .tcm_wdata (tcm_wdata),
      .tcm_rdata (tcm_rdata)
   );

   function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
      return (a == 14'h0010) ? 32'hDEADBEEF : {18'h2A5A5, a};
   endfunction

   function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] w, logic [BW-1:0] be);
      for (int b = 0; b < BW; b++) begin
         if (be[b]) o[8*b +: 8] = w[8*b +: 8];
      end
      return o;
   endfunction

   // TCM model: one-cycle read latency, byte-enable writes.
   logic [DW-1:0] mem [logic [AW-1:0]];
   always @(posedge clk) begin
      if (tcm_en) begin
         if (tcm_we != '0) begin
            mem[tcm_addr] = merge(mem.exists(tcm_addr) ? mem[tcm_addr] : init_val(tcm_addr),
                                  tcm_wdata, tcm_we);
         end else begin
            tcm_rdata <= mem.exists(tcm_addr) ? mem[tcm_addr] : init_val(tcm_addr);
         end
      end
   end

   // Scoreboard: shadow memory updated from the requester side on acceptance.
   logic [DW-1:0] shad [logic [AW-1:0]];
   typedef struct {
      logic [NP-1:0] port_oh;
      logic [DW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_pass = 0;
   int n_total = 0;

   logic [NP-1:0] ready_s, rspv_s;
   logic          en_s;
   logic [BW-1:0] we_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] rdata_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      exp_t e;
      logic [DW-1:0] old;
      @(negedge clk);
      ready_s = req_ready;
      rspv_s  = rsp_valid;
      en_s    = tcm_en;
      we_s    = tcm_we;
      addr_s  = tcm_addr;
      rdata_s = rsp_rdata;
      if (!rst) begin
         chk("rst_ready", 32'(ready_s), 0);
         chk("rst_en", 32'(en_s), 0);
         chk("rst_rsp", 32'(rspv_s), 0);
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_port", 32'(rspv_s), 32'(e.port_oh));
            chk("rsp_data", rdata_s, e.data);
            $display("rsp port_oh=%b data=%h", rspv_s, rdata_s);
         end else begin
            chk("rsp_idle", 32'(rspv_s), 0);
         end
         if (ready_s != '0) begin
            chk("ready_onehot", 32'($onehot(ready_s) && ((ready_s & ~v_valid) == '0)), 1);
            for (int p = 0; p < NP; p++) begin
               if (ready_s[p]) begin
                  chk("tcm_addr", 32'(addr_s), 32'(v_addr[p]));
                  chk("tcm_we", 32'(we_s), v_we[p] ? 32'(v_be[p]) : 0);
                  old = shad.exists(v_addr[p]) ? shad[v_addr[p]] : init_val(v_addr[p]);
                  if (v_we[p]) begin
                     shad[v_addr[p]] = merge(old, v_wdata[p], v_be[p]);
                     $display("acc port %0d WR addr=%h be=%b data=%h", p, v_addr[p], v_be[p], v_wdata[p]);
                  end else begin
                     e.port_oh = NP'(1 << p);
                     e.data    = old;
                     exp_q.push_back(e);
                     $display("acc port %0d RD addr=%h exp=%h", p, v_addr[p], old);
                  end
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [NP-1:0] valid;
      logic [NP-1:0] ready;
   } vec_t;
   vec_t tbl [18];

   initial begin
      tbl[0]  = '{3'b011, 3'b001};
      tbl[1]  = '{3'b011, 3'b001};
      tbl[2]  = '{3'b011, 3'b001};
      tbl[3]  = '{3'b011, 3'b001};
      tbl[4]  = '{3'b011, 3'b010};
      tbl[5]  = '{3'b011, 3'b010};
      tbl[6]  = '{3'b011, 3'b010};
      tbl[7]  = '{3'b011, 3'b010};
      tbl[8]  = '{3'b011, 3'b001};
      tbl[9]  = '{3'b000, 3'b000};
      tbl[10] = '{3'b100, 3'b100};
      tbl[11] = '{3'b111, 3'b100};
      tbl[12] = '{3'b111, 3'b100};
      tbl[13] = '{3'b111, 3'b100};
      tbl[14] = '{3'b111, 3'b001};
      tbl[15] = '{3'b110, 3'b010};
      tbl[16] = '{3'b101, 3'b100};
      tbl[17] = '{3'b001, 3'b001};

      for (int p = 0; p < NP; p++) begin
         v_addr[p]  = AW'(14'h0020 + p);
         v_we[p]    = 1'b0;
         v_be[p]    = '0;
         v_wdata[p] = '0;
      end

      // Reset held with every port requesting.
      v_valid = 3'b111;
      rst = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      chk("first_grant", 32'(ready_s), 32'(3'b001));
      v_valid = 3'b000;
      tick();

      // Single read from port 1.
      v_addr[1] = 14'h0010;
      v_valid = 3'b010;
      tick();
      chk("single_ready", 32'(ready_s), 32'(3'b010));
      v_valid = 3'b000;
      tick();
      chk("single_rspv", 32'(rspv_s), 32'(3'b010));
      chk("single_rdata", rdata_s, 32'hDEADBEEF);
      tick();

      // Grant-order table from a fresh reset.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int p = 0; p < NP; p++) v_addr[p] = AW'(14'h0020 + p);
      for (int i = 0; i < 18; i++) begin
         v_valid = tbl[i].valid;
         tick();
         chk("tbl_ready", 32'(ready_s), 32'(tbl[i].ready));
         chk("tbl_en", 32'(en_s), 32'(|tbl[i].ready));
      end
      v_valid = 3'b000;
      tick();

      // Lone requester streaming writes.
      v_we[2] = 1'b1;
      v_be[2] = 4'b0011;
      v_valid = 3'b100;
      for (int i = 0; i < 20; i++) begin
         v_addr[2]  = AW'(14'h0100 + i);
         v_wdata[2] = $urandom;
         tick();
         chk("lone_ready", 32'(ready_s), 32'(3'b100));
         chk("lone_en", 32'(en_s), 1);
         chk("lone_we", 32'(we_s), 32'(4'b0011));
         chk("lone_addr", 32'(addr_s), 32'(14'h0100 + i));
         chk("lone_rsp", 32'(rspv_s), 0);
      end
      v_valid = 3'b000;
      tick();

      // Mixed random traffic: port 0 reads, port 1 writes, port 2 reads.
      v_we[0] = 1'b0;
      v_we[1] = 1'b1;
      v_we[2] = 1'b0;
      for (int c = 0; c < 300; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (ready_s[p]) v_valid[p] = 1'b0;
            if (!v_valid[p] && ($urandom_range(0, 1) == 1)) begin
               v_addr[p]  = AW'($urandom_range(0, 7));
               v_be[p]    = BW'($urandom);
               v_wdata[p] = $urandom;
               v_valid[p] = 1'b1;
            end
         end
         tick();
      end
      v_valid = 3'b000;
      tick();
      tick();
      chk("sb_empty", 32'(exp_q.size()), 0);

      // Reset during the response cycle of a read.
      v_we[1]   = 1'b0;
      v_addr[1] = 14'h0010;
      v_valid = 3'b010;
      tick();
      chk("mid_grant", 32'(ready_s), 32'(3'b010));
      v_valid = 3'b000;
      rst = 1'b0;
      tick();
      chk("mid_rsp_drop", 32'(rspv_s), 0);
      tick();
      rst = 1'b1;
      v_we[0] = 1'b0;
      v_we[2] = 1'b0;
      v_valid = 3'b111;
      tick();
      chk("post_rst_grant", 32'(ready_s), 32'(3'b001));
      v_valid = 3'b000;
      tick();
      tick();
      chk("final_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
